fix_convert: RTL
================

# fix_convert

Pipelined fixed-point requantiser sitting directly downstream of the `add` stage. It takes the full-precision signed sum, rounds away the excess fractional bits, then saturates or wraps the result into a narrower signed format. Data moves with a valid/ready handshake so it can feed back-pressured consumers such as FIFOs or the next arithmetic stage.

## Interface
- `N_BITS_IN`, default 10: input word width, two's complement. Matches the adder's output width.
- `BIN_PT_IN`, default 8: input binary point, counted as fractional bits.
- `N_BITS_OUT`, default 8: output word width, two's complement.
- `BIN_PT_OUT`, default 6: output binary point. Legal only if `BIN_PT_OUT <= BIN_PT_IN`; elaboration fails otherwise.
- `clk`, input, 1: sole clock, rising edge. One clock; reset is synchronous and active-high.
- `rst`, input, 1: synchronous, active-high reset.
- `in_data`, input, `N_BITS_IN`: signed input sample.
- `in_valid`, input, 1: `in_data` is valid.
- `in_ready`, output, 1: the block accepts a sample this cycle.
- `out_data`, output, `N_BITS_OUT`: converted sample.
- `out_valid`, output, 1: `out_data` is valid.
- `out_ready`, input, 1: the consumer accepts `out_data`.
- `out_ovf`, output, 1: the current `out_data` overflowed (it was saturated or wrapped).
- `ovf_sticky`, output, 1: latched OR of every overflow since it was last cleared.
- `clr_ovf`, input, 1: clears `ovf_sticky`.

## Operation
- Let D = `BIN_PT_IN - BIN_PT_OUT`, the number of fractional bits dropped.
- Stage 1, round:
  - Sign-extend the input to `N_BITS_IN+1` bits.
  - If D>0, add 2^(D-1), then arithmetic-shift right by D. This is round-half-up (toward +inf).
  - If D=0, pass the value through unchanged.
  - The rounded value R is `N_BITS_IN+1-D` bits wide.
  - No overflow is possible here, because of the extra bit.
- Stage 2, narrow to `N_BITS_OUT`:
  - Overflow means R lies outside [-2^(N_BITS_OUT-1), 2^(N_BITS_OUT-1)-1].
  - On overflow the result is saturated or wrapped, as set under Configuration.
  - `out_ovf` is registered alongside `out_data`.
  - If R is narrower than or equal to `N_BITS_OUT`, sign-extend it. Overflow is then constant 0.
- Pipeline enable `en = !out_valid || out_ready`.
  - Both stages advance only when `en` is high.
  - `in_ready = en`, a combinational function of registered `out_valid` and of `out_ready`.
- A transfer happens on any cycle with `in_valid && in_ready`.
- Valid bits per stage:
  - `s1_valid` loads `in_valid` on `en`.
  - `out_valid` loads `s1_valid` on `en`.
- Bubbles collapse: an empty stage never blocks upstream.
- Data registers update only when `en` is high. Their value is don't-care while the matching valid is low.
- Sticky overflow:
  - `ovf_sticky` sets on any cycle where a sample with `out_ovf=1` enters the output register.
  - `clr_ovf` clears it the next cycle.
  - If a clear and a set happen in the same cycle, the set wins.

## Timing
- Latency is 2 cycles from an input transfer to `out_valid`, with `out_ready` held high.
- Throughput is 1 sample per cycle while `out_ready=1`.
- While stalled (`out_valid && !out_ready`):
  - `in_ready=0`.
  - `out_data`, `out_ovf` and the stage-1 contents hold stable.
  - Up to 2 samples are held.
- Reset values: `s1_valid=0`, `out_valid=0`, `out_data=0`, `out_ovf=0`, `ovf_sticky=0`.
  - `in_ready` reads 1 during and after reset.
- Reset mid-stream discards in-flight samples. `in_ready` stays 1 through reset.
- `in_valid` may drop without any transfer. Nothing is required to stay stable when `in_ready=0`.

## Configuration
- `FIX_CONVERT_SAT_EN` defined: on overflow, `out_data` clamps to 2^(N_BITS_OUT-1)-1 for positive R, or to -2^(N_BITS_OUT-1) for negative R.
- `FIX_CONVERT_SAT_EN` undefined: on overflow, `out_data` takes the low `N_BITS_OUT` bits of R (wrap).
- `out_ovf` and `ovf_sticky` behave identically in both modes.

## Test plan
All cases use the default parameters, so D=2.
- Rounding:
  - Inputs 0x005, 0x006, 0x3FE, with `out_ready=1`.
  - Required: `out_data` 0x01, 0x02, 0x00 on cycles 2, 3, 4 after the first transfer; `out_ovf=0` throughout.
- Negative limit:
  - Input 0x200 (-2.0).
  - Required: `out_data=0x80`, `out_ovf=0`.
- Positive overflow:
  - Input 0x1FF.
  - Required with saturation: `out_data=0x7F`, `out_ovf=1`, `ovf_sticky=1` from the next cycle.
  - Required without saturation: `out_data=0x80`, `out_ovf=1`.
- Back-pressure:
  - Stream 0x004, 0x008, 0x00C; hold `out_ready=0` for 5 cycles after the first output.
  - Required: `in_ready=0` while stalled, `out_data=0x01` held stable.
  - On release, 0x02 then 0x03 follow on consecutive cycles, with no loss or duplication.
- Sticky clear race:
  - Assert `clr_ovf` in the same cycle an overflowing sample loads.
  - Required: `ovf_sticky` stays 1.
  - A later `clr_ovf` with no overflow gives `ovf_sticky=0`.
- Reset mid-stream:
  - Assert `rst` with 2 samples in flight.
  - Required: next cycle `out_valid=0`, `out_data=0`, `ovf_sticky=0`, `in_ready=1`; no stale outputs afterwards.

Source files
------------

// File: rtl/fix_convert.sv
// fix_convert: two-stage round-half-up requantiser with a valid/ready handshake.
// Define FIX_CONVERT_SAT_EN to saturate on overflow; otherwise the result wraps.
module fix_convert #(
    parameter int N_BITS_IN  = 10,
    parameter int BIN_PT_IN  = 8,
    parameter int N_BITS_OUT = 8,
    parameter int BIN_PT_OUT = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_BITS_IN-1:0]  in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [N_BITS_OUT-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_ovf,
    output logic                  ovf_sticky,
    input  logic                  clr_ovf
);
    localparam int D  = BIN_PT_IN - BIN_PT_OUT;
    localparam int W1 = N_BITS_IN + 1;
    localparam int RW = W1 - D;

    if (BIN_PT_OUT > BIN_PT_IN) begin : g_bad_param
        $error("fix_convert: BIN_PT_OUT must not exceed BIN_PT_IN");
    end

    logic                  en;
    logic                  s1_valid;
    logic [W1-1:0]         ext;
    logic [RW-1:0]         r_next;
    logic [RW-1:0]         s1_r;
    logic [N_BITS_OUT-1:0] nxt;
    logic                  nxt_ovf;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;
    assign ext      = {in_data[N_BITS_IN-1], in_data};

    // The extra sign bit absorbs the +half carry, so the shift can never overflow.
    if (D > 0) begin : g_rnd
        logic [W1-1:0] sum;
        assign sum    = ext + W1'(1 << (D - 1));
        assign r_next = sum[W1-1:D];
    end else begin : g_pass
        assign r_next = ext;
    end

    // R fits iff every bit above the output sign bit equals that sign bit.
    if (RW > N_BITS_OUT) begin : g_narrow
        logic [RW-N_BITS_OUT:0] hi;
        assign hi      = s1_r[RW-1:N_BITS_OUT-1];
        assign nxt_ovf = !(&hi || !(|hi));
`ifdef FIX_CONVERT_SAT_EN
        assign nxt = nxt_ovf ? {s1_r[RW-1], {(N_BITS_OUT-1){!s1_r[RW-1]}}}
                             : s1_r[N_BITS_OUT-1:0];
`else
        assign nxt = s1_r[N_BITS_OUT-1:0];
`endif
    end else begin : g_wide
        assign nxt     = N_BITS_OUT'($signed(s1_r));
        assign nxt_ovf = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_ovf    <= 1'b0;
            ovf_sticky <= 1'b0;
        end else begin
            if (en) begin
                s1_valid  <= in_valid;
                s1_r      <= r_next;
                out_valid <= s1_valid;
                out_data  <= nxt;
                out_ovf   <= s1_valid && nxt_ovf;
            end
            ovf_sticky <= (en && s1_valid && nxt_ovf) || (ovf_sticky && !clr_ovf);
        end
    end
endmodule
